pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
PWM receiver/decoder, the inverse of the PWM generator path. It samples an external PWM waveform, measures high time and period in clk cycles, and recovers the duty reference as a RESOLUTION_BITS-wide value using duty = floor(high*2^N/period). It sits on the input side of a board: loopback of the generator's pwm_out, or an external PWM source feeding control logic.

Parameters:
RESOLUTION_BITS, 8, width N of recovered duty; matches the generator resolution.
CNT_BITS, 20, width of the high-time and period counters; sets the timeout at 2^CNT_BITS-1 cycles.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
pwm_in  input  1  asynchronous PWM input
duty  output  RESOLUTION_BITS  last recovered duty; held between updates
duty_valid  output  1  one-cycle pulse when duty updates
period  output  CNT_BITS  last measured period in clk cycles
high_time  output  CNT_BITS  last measured high time in clk cycles
timeout  output  1  level; no rising edge seen within the counter range
overrun  output  1  one-cycle pulse when a completed period is dropped
busy  output  1  divider running

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - duty, period, high_time = 0.
  - duty_valid, overrun, busy, timeout = 0.
  - Synchronizer flops = 0; FSM = SEEK.
  - Reset mid-division aborts the division with no duty_valid.
- Input sync and edge detect:
  - 2-flop synchronizer produces pwm_s; a third flop produces pwm_d.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - Edge detection lags pwm_in by 3 cycles.
- Measurement FSM:
  - SEEK: wait for rise; fall is ignored. On rise: period_cnt = 1, high_cnt = 1, go to HIGH.
  - HIGH: period_cnt++ and high_cnt++ every cycle. On fall: period_cnt++ only, go to LOW.
  - LOW: period_cnt++ every cycle. On rise, the period completes:
    - Latch period = period_cnt and high_time = high_cnt.
    - Clear timeout.
    - Hand the pair to the divider.
    - Restart both counters at 1 and go to HIGH.
- Timeout:
  - Applies in any measuring state, including SEEK.
  - Trigger: period_cnt reaches all-ones.
  - Actions:
    - Set timeout = 1.
    - Set duty = 0 if pwm_s is low, or all-ones if pwm_s is high.
    - Pulse duty_valid.
    - Set period = 0 and high_time = 0.
    - Go to SEEK with counters cleared.
  - In SEEK the counter keeps running, so timeout results re-emit every 2^CNT_BITS-1 cycles while the line stays static.
  - A timeout event in the same cycle as divider completion: the timeout result wins and the divider result is discarded.
- Divider (restoring, independent of the measurement FSM):
  - Load cycle: r = high_time (width CNT_BITS+1), q = 0, busy = 1.
  - Then N iterations, one per cycle:
    - r = r<<1.
    - If r >= period: r -= period and the quotient bit = 1; otherwise the bit = 0.
    - Quotient is built MSB first.
  - The cycle after the last iteration: duty = q, duty_valid = 1, busy = 0.
  - Latency from the completing rise to duty_valid = N+1 cycles.
  - high < period always holds, so q <= 2^N-1. The result still saturates to all-ones defensively.
- Overrun: if a period completes while busy = 1, that measurement is dropped and overrun pulses. The period and high_time outputs still update. Minimum decodable period = N+2 cycles.
- Simultaneous rise and timeout: the rise is processed and the timeout is suppressed.

Optional Feature:
PWM_CAPTURE_AVG_EN.
- Defined:
  - duty = floor(sum of the last 4 divider results / 4), using a 4-entry history and an (N+2)-bit sum.
  - duty_valid pulses only once 4 results have accumulated since reset or the last timeout.
  - A timeout bypasses the average, clears the history, and outputs 0 or all-ones directly.
- Undefined: duty is the raw divider result per period; there is no history logic.

Test Plan:
- Reset mid-division: assert rst for 1 cycle during busy -> all outputs 0, no duty_valid, FSM SEEK.
- Square wave, 64 cycles high / 192 low, repeated (N=8) -> period=256, high_time=64, duty=64, duty_valid N+1=9 cycles after each completing rise.
- Extremes at period 256: 1 high / 255 low -> duty=1; 255 high / 1 low -> duty=255; 3-cycle period with 1 high -> duty=85.
- Static line after running (CNT_BITS=10 for sim): pwm_in held low -> timeout=1, duty=0, duty_valid at 1023-cycle intervals. Held high -> duty=255. A following normal period clears timeout.
- Overrun: periods of 5 cycles with N=8 -> overrun pulses; only non-overlapping results produce duty_valid.
- With PWM_CAPTURE_AVG_EN: duties 60, 64, 68, 72 -> first duty_valid only after the 4th result, duty=66.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: PWM receiver/decoder.
// Synchronises an external PWM line, measures its high time and period in clk
// cycles, and recovers duty = floor(high * 2^N / period) with a restoring
// divider. A line that stays static for the whole counter range produces a
// timeout result of all-zeros or all-ones.
// Optional build macro PWM_CAPTURE_AVG_EN: when defined, duty is the average
// of the last four divider results instead of the raw per-period value.
module pwm_capture #(
    parameter int RESOLUTION_BITS = 8,
    parameter int CNT_BITS        = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwm_in,
    output logic [RESOLUTION_BITS-1:0] duty,
    output logic                       duty_valid,
    output logic [CNT_BITS-1:0]        period,
    output logic [CNT_BITS-1:0]        high_time,
    output logic                       timeout,
    output logic                       overrun,
    output logic                       busy
);

    localparam int N         = RESOLUTION_BITS;
    localparam int ITER_BITS = $clog2(N + 1);
    localparam logic [ITER_BITS-1:0] ITER_LAST = ITER_BITS'(N);
    // The timeout fires on the cycle the period counter would become all-ones,
    // so a static line re-emits a result every 2^CNT_BITS-1 cycles.
    localparam logic [CNT_BITS-1:0]  CNT_LAST  = {{(CNT_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        SEEK,
        HIGH,
        LOW
    } state_t;

    state_t state;
    state_t next_state;

    logic sync1;
    logic pwm_s;
    logic pwm_d;
    logic rise;
    logic fall;

    logic [CNT_BITS-1:0] period_cnt;
    logic [CNT_BITS-1:0] high_cnt;

    logic timeout_evt;
    logic restart;
    logic period_done;
    logic count_high;
    logic div_start;

    logic [CNT_BITS-1:0]  rem;
    logic [CNT_BITS:0]    rem_shift;
    logic [CNT_BITS-1:0]  den;
    logic [N-1:0]         quo;
    logic [ITER_BITS-1:0] iter;
    logic                 sat;
    logic                 quo_bit;
    logic                 div_done;
    logic [N-1:0]         div_result;
    logic [N-1:0]         static_duty;

    // Two-flop synchroniser on the asynchronous line plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d;
    assign fall = ~pwm_s & pwm_d;

    // Measurement FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= next_state;
        end
    end

    // Measurement FSM next-state logic; a rise always beats a timeout
    always_comb begin
        next_state = state;
        case (state)
            SEEK: begin
                if (rise) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (timeout_evt) begin
                    next_state = SEEK;
                end else if (fall) begin
                    next_state = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    next_state = HIGH;
                end else if (timeout_evt) begin
                    next_state = SEEK;
                end
            end
            default: next_state = SEEK;
        endcase
    end

    // Measurement FSM control strobes for counters, latches and divider
    always_comb begin
        timeout_evt = 1'b0;
        restart     = 1'b0;
        period_done = 1'b0;
        count_high  = 1'b0;
        timeout_evt = (period_cnt == CNT_LAST) && !rise;
        restart     = rise && (state != HIGH);
        period_done = rise && (state == LOW);
        count_high  = (state == HIGH) && !fall;
    end

    assign div_start = period_done && !busy;

    // Period and high-time counters; a rise restarts both at one
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (timeout_evt) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (restart) begin
            period_cnt <= CNT_BITS'(1);
            high_cnt   <= CNT_BITS'(1);
        end else begin
            period_cnt <= period_cnt + CNT_BITS'(1);
            if (count_high) begin
                high_cnt <= high_cnt + CNT_BITS'(1);
            end
        end
    end

    // Measurement outputs: latched on every completed period, even when the divider drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (timeout_evt) begin
                period    <= '0;
                high_time <= '0;
                timeout   <= 1'b1;
            end else if (period_done) begin
                period    <= period_cnt;
                high_time <= high_cnt;
                timeout   <= 1'b0;
                overrun   <= busy;
            end
        end
    end

    // The remainder stays below the divisor, so one extra bit holds the shifted value
    assign rem_shift  = {rem, 1'b0};
    assign quo_bit    = (rem_shift >= {1'b0, den});
    assign div_done   = busy && (iter == ITER_LAST);
    assign div_result = sat ? '1 : quo;
    assign static_duty = pwm_s ? '1 : '0;

    // Restoring divider: load cycle, N quotient bits MSB first, then a result cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            den  <= '0;
            quo  <= '0;
            iter <= '0;
            sat  <= 1'b0;
            busy <= 1'b0;
        end else if (timeout_evt) begin
            busy <= 1'b0;
        end else if (div_start) begin
            rem  <= high_cnt;
            den  <= period_cnt;
            quo  <= '0;
            iter <= '0;
            sat  <= (high_cnt >= period_cnt);
            busy <= 1'b1;
        end else if (busy) begin
            if (iter == ITER_LAST) begin
                busy <= 1'b0;
            end else begin
                if (quo_bit) begin
                    rem <= CNT_BITS'(rem_shift - {1'b0, den});
                end else begin
                    rem <= CNT_BITS'(rem_shift);
                end
                quo  <= {quo[N-2:0], quo_bit};
                iter <= iter + ITER_BITS'(1);
            end
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    localparam int SUM_BITS = N + 2;

    logic [N-1:0]        hist [3];
    logic [1:0]          hist_cnt;
    logic [SUM_BITS-1:0] avg_sum;

    // The newest divider result plus the three before it form the four-entry window
    assign avg_sum = SUM_BITS'(div_result) + SUM_BITS'(hist[0])
                   + SUM_BITS'(hist[1]) + SUM_BITS'(hist[2]);

    // Averaged duty output; a timeout bypasses the average and empties the history
    always_ff @(posedge clk) begin
        if (rst) begin
            hist[0]    <= '0;
            hist[1]    <= '0;
            hist[2]    <= '0;
            hist_cnt   <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (timeout_evt) begin
                hist[0]    <= '0;
                hist[1]    <= '0;
                hist[2]    <= '0;
                hist_cnt   <= '0;
                duty       <= static_duty;
                duty_valid <= 1'b1;
            end else if (div_done) begin
                hist[0] <= div_result;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                if (hist_cnt == 2'd3) begin
                    duty       <= avg_sum[SUM_BITS-1:2];
                    duty_valid <= 1'b1;
                end else begin
                    hist_cnt <= hist_cnt + 2'd1;
                end
            end
        end
    end
`else
    // Raw duty output; a timeout result in the same cycle discards the divider result
    always_ff @(posedge clk) begin
        if (rst) begin
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (timeout_evt) begin
                duty       <= static_duty;
                duty_valid <= 1'b1;
            end else if (div_done) begin
                duty       <= div_result;
                duty_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture with N=8 and CNT_BITS=10.
// Inputs change and outputs are sampled 1 time unit after each falling clock edge.
module tb_pwm_capture;

    localparam int N  = 8;
    localparam int CW = 10;
    // From the pwm_in change to the duty_valid sample: 3 cycles of edge detection plus N+1 of division
    localparam int LAT = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [N-1:0]  duty;
    logic          duty_valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          timeout;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_count = 0;
    int dv_cyc = 0;
    int ov_count = 0;
    logic [N-1:0] dv_duty = '0;

    pwm_capture #(
        .RESOLUTION_BITS(N),
        .CNT_BITS(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .duty(duty),
        .duty_valid(duty_valid),
        .period(period),
        .high_time(high_time),
        .timeout(timeout),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time duty_valid pulses
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Records every duty_valid and overrun pulse seen on the falling edge
    always @(negedge clk) begin
        if (duty_valid) begin
            dv_count <= dv_count + 1;
            dv_cyc   <= cyc;
            dv_duty  <= duty;
        end
        if (overrun) begin
            ov_count <= ov_count + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int h, input int l, output int rise_at);
        pwm_in  = 1'b1;
        rise_at = cyc;
        tick(h);
        pwm_in = 1'b0;
        tick(l);
    endtask

    task automatic checkPeriod(input string tag, input int dv_before, input int rise_at,
                               input int exp_duty, input int exp_period, input int exp_high);
        checkOutput({tag, "_count"}, dv_count - dv_before, 1);
        checkOutput({tag, "_latency"}, dv_cyc - rise_at, LAT);
        checkOutput({tag, "_duty"}, dv_duty, exp_duty);
        checkOutput({tag, "_duty_held"}, duty, exp_duty);
        checkOutput({tag, "_period"}, period, exp_period);
        checkOutput({tag, "_high"}, high_time, exp_high);
    endtask

    task automatic waitValid(input string tag, input int budget);
        int start;
        int n;
        start = dv_count;
        n = 0;
        while (dv_count == start && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_arrive"}, (dv_count != start) ? 1 : 0, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_duty"}, duty, 0);
        checkOutput({tag, "_duty_valid"}, duty_valid, 0);
        checkOutput({tag, "_period"}, period, 0);
        checkOutput({tag, "_high"}, high_time, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int r;
        int dv0;
        int ov0;
        int t1;

        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        checkAllZero("reset");
        rst = 1'b0;
        tick(5);

        $display("[TB] square wave and extremes");
        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkOutput("first_period_no_result", dv_count - dv0, 0);

        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkPeriod("sq1", dv0, r, 64, 256, 64);

        dv0 = dv_count;
        applyStimulus(1, 255, r);
        checkPeriod("sq2", dv0, r, 64, 256, 64);

        dv0 = dv_count;
        applyStimulus(255, 1, r);
        checkPeriod("min_high", dv0, r, 1, 256, 1);

        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkPeriod("max_high", dv0, r, 255, 256, 255);

        $display("[TB] static low line");
        waitValid("to_low1", 1100);
        checkOutput("to_low1_duty", dv_duty, 0);
        checkOutput("to_low1_timeout", timeout, 1);
        checkOutput("to_low1_period", period, 0);
        checkOutput("to_low1_high", high_time, 0);
        t1 = dv_cyc;
        waitValid("to_low2", 1100);
        checkOutput("to_low2_interval", dv_cyc - t1, 1023);
        checkOutput("to_low2_duty", dv_duty, 0);

        $display("[TB] static high line");
        pwm_in = 1'b1;
        waitValid("to_high", 1100);
        checkOutput("to_high_duty", dv_duty, 255);
        checkOutput("to_high_timeout", timeout, 1);
        checkOutput("to_high_period", period, 0);
        checkOutput("to_high_high", high_time, 0);

        $display("[TB] short period after timeout");
        pwm_in = 1'b0;
        tick(20);
        dv0 = dv_count;
        applyStimulus(1, 2, r);
        checkOutput("seek_start_no_result", dv_count - dv0, 0);
        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkPeriod("p3", dv0, r, 85, 3, 1);
        checkOutput("p3_timeout_cleared", timeout, 0);

        $display("[TB] overrun train");
        dv0 = dv_count;
        ov0 = ov_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2, 3, r);
        end
        applyStimulus(64, 192, r);
        checkOutput("ovr_pulses", ov_count - ov0, 4);
        checkOutput("ovr_results", dv_count - dv0, 5);
        checkOutput("ovr_latency", dv_cyc - r, LAT);
        checkOutput("ovr_duty", dv_duty, 102);
        checkOutput("ovr_period", period, 5);
        checkOutput("ovr_high", high_time, 2);

        $display("[TB] reset during division");
        pwm_in = 1'b1;
        tick(4);
        checkOutput("mid_div_busy", busy, 1);
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(1);
        rst = 1'b0;
        checkAllZero("mid_div_reset");
        dv0 = dv_count;
        tick(15);
        checkOutput("mid_div_no_valid", dv_count - dv0, 0);
        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkOutput("post_reset_seek", dv_count - dv0, 0);
        dv0 = dv_count;
        applyStimulus(64, 192, r);
        checkPeriod("post_reset", dv0, r, 64, 256, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
